// File: rtl/debug_trace_fifo.sv
// debug_trace_fifo
// ----------------
// Serialises up to LANES retired instructions per cycle into the
// single-record-per-cycle debug_wb_* trace format. Accepted lanes are packed
// into consecutive slots in program order. One record is popped into the
// output flops per cycle.
//
// Optional feature (compile-time macro):
//   TRACE_SKIP_NOWRITE_EN - when defined, commits with commit_wen=0 are not
//                           enqueued, so only register writes are traced.
//
// Parameters:
//   LANES  commit lanes per cycle, lane 0 oldest (1..4)
//   DEPTH  FIFO entries, power of two, >= 2*LANES
//
// Ports:
//   clk                in   clock, rising edge
//   reset              in   synchronous active-high reset
//   commit_valid       in   [LANES]     lane retires this cycle
//   commit_pc          in   [LANES*32]  retired PC per lane
//   commit_wen         in   [LANES]     lane writes the register file
//   commit_wnum        in   [LANES*5]   destination register per lane
//   commit_wdata       in   [LANES*32]  write data per lane
//   stall              out  core must not retire (from registered count only)
//   overflow           out  sticky: a commit was presented while stalled
//   debug_wb_pc        out  [32] emitted record PC
//   debug_wb_rf_wen    out  [4]  {4{wen}} of emitted record, 0 when idle
//   debug_wb_rf_wnum   out  [5]  emitted record destination
//   debug_wb_rf_wdata  out  [32] emitted record data

module debug_trace_fifo #(
   parameter int LANES = 2,
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [LANES-1:0]      commit_valid,
   input  logic [LANES*32-1:0]   commit_pc,
   input  logic [LANES-1:0]      commit_wen,
   input  logic [LANES*5-1:0]    commit_wnum,
   input  logic [LANES*32-1:0]   commit_wdata,
   output logic                  stall,
   output logic                  overflow,
   output logic [31:0]           debug_wb_pc,
   output logic [3:0]            debug_wb_rf_wen,
   output logic [4:0]            debug_wb_rf_wnum,
   output logic [31:0]           debug_wb_rf_wdata
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(DEPTH - LANES);

   typedef struct packed {
      logic [31:0] pc;
      logic        wen;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } trace_rec_t;

   trace_rec_t        mem [DEPTH];
   trace_rec_t        lane_rec [LANES];
   logic [PTR_W-1:0]  lane_off [LANES];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  push_cnt;
   logic [LANES-1:0]  enq_mask;
   logic [LANES-1:0]  accept;
   logic              pop;

`ifdef TRACE_SKIP_NOWRITE_EN
   assign enq_mask = commit_wen;
`else
   assign enq_mask = '1;
`endif

   // Stall looks only at the registered occupancy, so there is no
   // combinational path from commit_* back to the core.
   assign stall  = (count > STALL_LIMIT);
   assign accept = commit_valid & enq_mask & {LANES{~stall}};
   assign pop    = (count != '0);

   // Each accepted lane lands at tail + (number of accepted older lanes),
   // which squeezes out invalid lanes and keeps program order.
   // NOTE: combinational blocks use blocking '=' so the running push_cnt is
   // seen by the next loop iteration; clocked blocks use '<=' only.
   always_comb begin
      push_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_off[i]       = push_cnt[PTR_W-1:0];
         lane_rec[i].pc    = commit_pc[i*32 +: 32];
         lane_rec[i].wen   = commit_wen[i];
         lane_rec[i].wnum  = commit_wnum[i*5 +: 5];
         lane_rec[i].wdata = commit_wdata[i*32 +: 32];
         if (accept[i]) begin
            push_cnt = push_cnt + CNT_ONE;
         end
      end
   end

   // NOTE: the storage array has no reset; head/tail/count define which
   // entries are live, so stale contents are never emitted.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (accept[i] && !reset) begin
            mem[tail + lane_off[i]] <= lane_rec[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         overflow          <= 1'b0;
         debug_wb_pc       <= '0;
         debug_wb_rf_wen   <= '0;
         debug_wb_rf_wnum  <= '0;
         debug_wb_rf_wdata <= '0;
      end else begin
         // push_cnt <= LANES <= DEPTH/2, so it fits in a pointer.
         tail  <= tail + push_cnt[PTR_W-1:0];
         count <= count + push_cnt - CNT_W'(pop);
         if (stall && (|commit_valid)) begin
            overflow <= 1'b1;
         end
         // The pop reads the pre-edge head, so a same-edge push is never
         // bypassed to the output.
         if (pop) begin
            head              <= head + PTR_ONE;
            debug_wb_pc       <= mem[head].pc;
            debug_wb_rf_wen   <= {4{mem[head].wen}};
            debug_wb_rf_wnum  <= mem[head].wnum;
            debug_wb_rf_wdata <= mem[head].wdata;
         end else begin
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
         end
      end
   end

endmodule
